// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store buffer sharing one memory port with loads
// Define STORE_BUFFER_FWD_EN to forward an exact addr/size match from the youngest overlapping store.
module store_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [DATA_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [1:0]            st_size,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_addr,
  input  logic [1:0]            ld_size,
  input  logic                  ld_unsigned,
  output logic                  ld_rvalid,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic                  sb_empty,
  output logic [1:0]            mem_we,
  output logic [DATA_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [1:0]            size_q [DEPTH];
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [CNT_W-1:0]      count_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  enq, drain, load_fire, hazard, fwd_hit;
  logic [1:0]            ld_size_n;
  logic [PTR_W-1:0]      idx, fwd_idx;
  logic [DATA_WIDTH:0]   ld_lo, ld_hi, ent_lo, ent_hi;
  logic [DATA_WIDTH-1:0] ld_src, ld_fmt;
`ifdef STORE_BUFFER_FWD_EN
  logic                  match;
`endif

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      2'b10:   size_bytes = 3'd2;
      2'b11:   size_bytes = 3'd1;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  assign ld_size_n = (ld_size == 2'b00) ? 2'b01 : ld_size;
  assign ld_lo     = {1'b0, ld_addr};
  assign ld_hi     = ld_lo + {{(DATA_WIDTH-2){1'b0}}, size_bytes(ld_size_n)};

  // Oldest-to-youngest scan with half-open ranges; the last hit is the youngest overlap.
  always_comb begin
    hazard  = 1'b0;
    fwd_idx = head_q;
    idx     = head_q;
    ent_lo  = '0;
    ent_hi  = '0;
`ifdef STORE_BUFFER_FWD_EN
    match   = 1'b0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx    = head_q + PTR_W'(k);
      ent_lo = {1'b0, addr_q[idx]};
      ent_hi = ent_lo + {{(DATA_WIDTH-2){1'b0}}, size_bytes(size_q[idx])};
      if ((CNT_W'(k) < count_q) && (ld_lo < ent_hi) && (ent_lo < ld_hi)) begin
        hazard  = 1'b1;
        fwd_idx = idx;
`ifdef STORE_BUFFER_FWD_EN
        match   = (addr_q[idx] == ld_addr) && (size_q[idx] == ld_size_n);
`endif
      end
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  assign fwd_hit = hazard && match;
`else
  assign fwd_hit = 1'b0;
`endif

  assign st_ready  = (count_q != CNT_W'(DEPTH));
  assign sb_empty  = (count_q == '0);
  assign ld_ready  = !hazard || fwd_hit;
  assign load_fire = ld_valid && ld_ready;
  assign drain     = !load_fire && (count_q != '0);
  assign enq       = st_valid && st_ready && (st_size != 2'b00);

  assign mem_a  = load_fire ? ld_addr : addr_q[head_q];
  assign mem_wd = data_q[head_q];
  assign mem_we = drain ? size_q[head_q] : 2'b00;

  assign ld_src = fwd_hit ? data_q[fwd_idx] : mem_rd;

  always_comb begin
    ld_fmt = ld_src;
    case (ld_size_n)
      2'b11:   ld_fmt = ld_unsigned ? {{(DATA_WIDTH-8){1'b0}}, ld_src[7:0]}
                                    : {{(DATA_WIDTH-8){ld_src[7]}}, ld_src[7:0]};
      2'b10:   ld_fmt = ld_unsigned ? {{(DATA_WIDTH-16){1'b0}}, ld_src[15:0]}
                                    : {{(DATA_WIDTH-16){ld_src[15]}}, ld_src[15:0]};
      default: ld_fmt = ld_src;
    endcase
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
      size_q[tail_q] <= st_size;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (enq)   tail_q <= tail_q + PTR_W'(1);
      if (drain) head_q <= head_q + PTR_W'(1);
      count_q  <= count_q + CNT_W'(enq) - CNT_W'(drain);
      rvalid_q <= load_fire;
      if (load_fire) rdata_q <= ld_fmt;
    end
  end

  assign ld_rvalid = rvalid_q;
  assign ld_data   = rdata_q;
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed bench for store_buffer with a byte-addressed memory model
module tb_store_buffer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid, st_ready;
  logic [31:0] st_addr, st_data;
  logic [1:0]  st_size;
  logic        ld_valid, ld_ready, ld_unsigned, ld_rvalid;
  logic [31:0] ld_addr, ld_data;
  logic [1:0]  ld_size;
  logic        sb_empty;
  logic [1:0]  mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  int checks = 0;
  int errors = 0;
  int writes_seen = 0;
  int w0;

  logic [7:0]  mem [0:4095];
  logic [11:0] ma;

  store_buffer #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_size(ld_size), .ld_unsigned(ld_unsigned),
    .ld_rvalid(ld_rvalid), .ld_data(ld_data), .sb_empty(sb_empty),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign ma     = mem_a[11:0];
  assign mem_rd = {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};

  // Little-endian memory; 0x10100 is preloaded with 0xF0DEBC9A.
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h100] = 8'h9A; mem[12'h101] = 8'hBC; mem[12'h102] = 8'hDE; mem[12'h103] = 8'hF0;
    forever begin
      @(posedge clk);
      if (mem_we != 2'b00) begin
        writes_seen <= writes_seen + 1;
        mem[ma] <= mem_wd[7:0];
        if (mem_we != 2'b11) mem[ma + 12'd1] <= mem_wd[15:8];
        if (mem_we == 2'b01) begin
          mem[ma + 12'd2] <= mem_wd[23:16];
          mem[ma + 12'd3] <= mem_wd[31:24];
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Keeps the port busy with a harmless load so stores accumulate.
  task automatic fill(input int n, input logic [31:0] base, input logic [31:0] dbase);
    ld_valid = 1'b1; ld_addr = 32'h0001_0800; ld_size = 2'b01; ld_unsigned = 1'b0;
    for (int i = 0; i < n; i++) begin
      st_valid = 1'b1; st_addr = base + 32'(4 * i); st_data = dbase + 32'(i); st_size = 2'b01;
      tick;
    end
    st_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] s,
                         input logic u, input logic [31:0] exp);
    ld_valid = 1'b1; ld_addr = a; ld_size = s; ld_unsigned = u;
    #1 chk({tag, " ld_ready"}, 32'(ld_ready), 32'd1);
    tick;
    ld_valid = 1'b0;
    chk({tag, " ld_rvalid"}, 32'(ld_rvalid), 32'd1);
    chk({tag, " ld_data"}, ld_data, exp);
  endtask

  task automatic drain_chk(input string tag, input logic [1:0] we, input logic [31:0] a, input logic [31:0] d);
    #1;
    chk({tag, " mem_we"}, 32'(mem_we), 32'(we));
    chk({tag, " mem_a"}, mem_a, a);
    chk({tag, " mem_wd"}, mem_wd, d);
    tick;
  endtask

  initial begin
    rst_n = 1'b0;
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = 2'b00;
    ld_valid = 1'b0; ld_addr = '0; ld_size = 2'b00; ld_unsigned = 1'b0;
    repeat (2) tick;
    chk("rst st_ready", 32'(st_ready), 32'd1);
    chk("rst sb_empty", 32'(sb_empty), 32'd1);
    chk("rst ld_ready", 32'(ld_ready), 32'd1);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst ld_rvalid", 32'(ld_rvalid), 32'd0);
    chk("rst ld_data", ld_data, 32'd0);
    rst_n = 1'b1;
    tick;

    // size 00 store is accepted and dropped
    st_valid = 1'b1; st_addr = 32'h0001_0050; st_data = 32'h1234_5678; st_size = 2'b00;
    #1 chk("sz0 st_ready", 32'(st_ready), 32'd1);
    tick;
    st_valid = 1'b0;
    chk("sz0 sb_empty", 32'(sb_empty), 32'd1);
    chk("sz0 mem_we", 32'(mem_we), 32'd0);

    // fill to four entries, then drain in FIFO order
    ld_valid = 1'b1; ld_addr = 32'h0001_0800; ld_size = 2'b01;
    st_valid = 1'b1; st_addr = 32'h0001_0000; st_data = 32'h1122_3344; st_size = 2'b01; tick;
    st_addr = 32'h0001_0004; st_data = 32'h5566_7788; st_size = 2'b01; tick;
    st_addr = 32'h0001_0008; st_data = 32'hAAAA_BEEF; st_size = 2'b10; tick;
    st_addr = 32'h0001_000C; st_data = 32'h0000_00C5; st_size = 2'b11; tick;
    st_valid = 1'b0;
    #1;
    chk("full st_ready", 32'(st_ready), 32'd0);
    chk("full sb_empty", 32'(sb_empty), 32'd0);
    chk("full load mem_we", 32'(mem_we), 32'd0);
    ld_valid = 1'b0;
    drain_chk("drain0", 2'b01, 32'h0001_0000, 32'h1122_3344);
    drain_chk("drain1", 2'b01, 32'h0001_0004, 32'h5566_7788);
    drain_chk("drain2", 2'b10, 32'h0001_0008, 32'hAAAA_BEEF);
    drain_chk("drain3", 2'b11, 32'h0001_000C, 32'h0000_00C5);
    chk("drained sb_empty", 32'(sb_empty), 32'd1);
    chk("drained mem_we", 32'(mem_we), 32'd0);

    do_load("lw", 32'h0001_0000, 2'b01, 1'b0, 32'h1122_3344);
    do_load("lw sz0", 32'h0001_0004, 2'b00, 1'b0, 32'h5566_7788);
    do_load("lh", 32'h0001_0008, 2'b10, 1'b0, 32'hFFFF_BEEF);
    do_load("lhu", 32'h0001_0008, 2'b10, 1'b1, 32'h0000_BEEF);
    do_load("lbu", 32'h0001_000C, 2'b11, 1'b1, 32'h0000_00C5);
    do_load("lb", 32'h0001_000C, 2'b11, 1'b0, 32'hFFFF_FFC5);
    tick;
    chk("hold ld_rvalid", 32'(ld_rvalid), 32'd0);
    chk("hold ld_data", ld_data, 32'hFFFF_FFC5);

    // byte store then matching byte load
    st_valid = 1'b1; st_addr = 32'h0001_0004; st_data = 32'h0000_0080; st_size = 2'b11;
    tick;
    st_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h0001_0004; ld_size = 2'b11; ld_unsigned = 1'b0;
    #1;
`ifdef STORE_BUFFER_FWD_EN
    chk("fwd ld_ready", 32'(ld_ready), 32'd1);
    chk("fwd mem_we", 32'(mem_we), 32'd0);
    tick;
    ld_valid = 1'b0;
    chk("fwd ld_rvalid", 32'(ld_rvalid), 32'd1);
    chk("fwd ld_data", ld_data, 32'hFFFF_FF80);
    #1 chk("fwd later drain", 32'(mem_we), 32'd3);
    tick;
`else
    chk("stall ld_ready", 32'(ld_ready), 32'd0);
    chk("stall mem_we", 32'(mem_we), 32'd3);
    chk("stall mem_a", mem_a, 32'h0001_0004);
    tick;
    #1 chk("unstall ld_ready", 32'(ld_ready), 32'd1);
    tick;
    ld_valid = 1'b0;
    chk("stall ld_rvalid", 32'(ld_rvalid), 32'd1);
    chk("stall ld_data", ld_data, 32'hFFFF_FF80);
`endif
    chk("byte sb_empty", 32'(sb_empty), 32'd1);

    // word store, partially overlapping half load stalls in both builds
    st_valid = 1'b1; st_addr = 32'h0001_0000; st_data = 32'hCAFE_F00D; st_size = 2'b01;
    tick;
    st_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h0001_0002; ld_size = 2'b10; ld_unsigned = 1'b0;
    #1;
    chk("part ld_ready", 32'(ld_ready), 32'd0);
    chk("part mem_we", 32'(mem_we), 32'd1);
    chk("part mem_a", mem_a, 32'h0001_0000);
    tick;
    #1 chk("part ld_ready after", 32'(ld_ready), 32'd1);
    tick;
    ld_valid = 1'b0;
    chk("part ld_rvalid", 32'(ld_rvalid), 32'd1);
    chk("part ld_data", ld_data, 32'hFFFF_CAFE);

    // non-overlapping load takes the port ahead of two pending stores
    fill(2, 32'h0001_0010, 32'h0102_0304);
    ld_addr = 32'h0001_0100;
    #1;
    chk("prio ld_ready", 32'(ld_ready), 32'd1);
    chk("prio mem_we", 32'(mem_we), 32'd0);
    chk("prio mem_a", mem_a, 32'h0001_0100);
    tick;
    ld_valid = 1'b0;
    chk("prio ld_rvalid", 32'(ld_rvalid), 32'd1);
    chk("prio ld_data", ld_data, 32'hF0DE_BC9A);
    drain_chk("prio drain0", 2'b01, 32'h0001_0010, 32'h0102_0304);
    drain_chk("prio drain1", 2'b01, 32'h0001_0014, 32'h0102_0305);
    chk("prio sb_empty", 32'(sb_empty), 32'd1);

    // full buffer: store waits one cycle while the head drains
    fill(4, 32'h0001_0020, 32'h0000_0100);
    ld_valid = 1'b0;
    st_valid = 1'b1; st_addr = 32'h0001_0030; st_data = 32'h0000_0055; st_size = 2'b01;
    #1 chk("fulldr st_ready", 32'(st_ready), 32'd0);
    drain_chk("fulldr drain0", 2'b01, 32'h0001_0020, 32'h0000_0100);
    #1 chk("fulldr st_ready next", 32'(st_ready), 32'd1);
    drain_chk("fulldr drain1", 2'b01, 32'h0001_0024, 32'h0000_0101);
    st_valid = 1'b0;
    drain_chk("fulldr drain2", 2'b01, 32'h0001_0028, 32'h0000_0102);
    drain_chk("fulldr drain3", 2'b01, 32'h0001_002C, 32'h0000_0103);
    drain_chk("fulldr drain4", 2'b01, 32'h0001_0030, 32'h0000_0055);
    chk("fulldr sb_empty", 32'(sb_empty), 32'd1);

    // reset mid-drain discards three entries
    fill(3, 32'h0001_0040, 32'hDEAD_0000);
    ld_valid = 1'b0;
    #1;
    chk("rstdr mem_we before", 32'(mem_we), 32'd1);
    chk("rstdr mem_a before", mem_a, 32'h0001_0040);
    w0 = writes_seen;
    rst_n = 1'b0;
    #1;
    chk("rstdr mem_we", 32'(mem_we), 32'd0);
    chk("rstdr sb_empty", 32'(sb_empty), 32'd1);
    tick;
    rst_n = 1'b1;
    repeat (5) tick;
    chk("rstdr writes", 32'(writes_seen), 32'(w0));
    chk("rstdr sb_empty after", 32'(sb_empty), 32'd1);
    chk("rstdr mem_we after", 32'(mem_we), 32'd0);
    do_load("rstdr mem", 32'h0001_0040, 2'b01, 1'b0, 32'h0000_0000);

    // reset with a response in flight
    do_load("rstld", 32'h0001_0000, 2'b01, 1'b0, 32'hCAFE_F00D);
    rst_n = 1'b0;
    #1;
    chk("rstld ld_rvalid", 32'(ld_rvalid), 32'd0);
    chk("rstld ld_data", ld_data, 32'd0);
    tick;
    rst_n = 1'b1;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
